// File: rtl/alu_pkg.sv
// Shared command encodings, flag bit positions and FSM state type for seq_alu.
package alu_pkg;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_ADC = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_SBC = 4'b0011;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SHL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Flags for ops that never produce carry or overflow (logic ops, multiply).
    function automatic logic [3:0] nz_flags(input logic n, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/command and result handshake bundle between the ID/EX and EX/MEM stages.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             illegal;

    modport master (
        output in_valid, exe_cmd, val1, val2, c_in, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );

    modport slave (
        input  in_valid, exe_cmd, val1, val2, c_in, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: arithmetic, logic and shifts with NZCV flags.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic [3:0]       i_cmd,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags,
    output logic             o_illegal
);
    localparam int SH_W = $clog2(WIDTH);

    logic                    w_sub;
    logic                    w_cin;
    logic [WIDTH-1:0]        w_b_op;
    logic [WIDTH:0]          w_sum;
    logic                    w_ovf;
    logic [SH_W-1:0]         w_amt;
    logic                    w_amt_big;
    logic [WIDTH:0]          w_shl_ext;
    logic [WIDTH:0]          w_srl_ext;
    logic signed [WIDTH:0]   w_sra_ext;
    logic [WIDTH-1:0]        w_res;
    logic                    w_c;
    logic                    w_v;
    logic                    w_ill;

    // Subtraction is A + ~B + carry, so carry-out is the ARM no-borrow flag.
    assign w_sub  = (i_cmd == CMD_SUB) || (i_cmd == CMD_SBC);
    assign w_b_op = w_sub ? ~i_b : i_b;
    assign w_cin  = (i_cmd == CMD_SUB) ? 1'b1 :
                    ((i_cmd == CMD_ADC) || (i_cmd == CMD_SBC)) ? i_c_in : 1'b0;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf  = (i_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // One extra bit on the far side of each shift captures the last bit shifted out.
    assign w_amt     = i_b[SH_W-1:0];
    assign w_amt_big = |i_b[WIDTH-1:SH_W];
    assign w_shl_ext = {1'b0, i_a} << w_amt;
    assign w_srl_ext = {i_a, 1'b0} >> w_amt;
    assign w_sra_ext = $signed({i_a, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (i_cmd)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_ovf;
            end
            CMD_AND: w_res = i_a & i_b;
            CMD_OR:  w_res = i_a | i_b;
            CMD_NOR: w_res = ~(i_a | i_b);
            CMD_XOR: w_res = i_a ^ i_b;
            CMD_SHL: begin
                w_res = w_amt_big ? '0 : w_shl_ext[WIDTH-1:0];
                w_c   = w_amt_big ? 1'b0 : w_shl_ext[WIDTH];
            end
            CMD_SRL: begin
                w_res = w_amt_big ? '0 : w_srl_ext[WIDTH:1];
                w_c   = w_amt_big ? 1'b0 : w_srl_ext[0];
            end
            CMD_SRA: begin
                w_res = w_amt_big ? {WIDTH{i_a[WIDTH-1]}} : w_sra_ext[WIDTH:1];
                w_c   = w_amt_big ? i_a[WIDTH-1] : w_sra_ext[0];
            end
            CMD_MUL: w_ill = (MUL_EN == 1'b0);
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        o_flags         = 4'b0000;
        o_flags[FLAG_N] = w_res[WIDTH-1];
        o_flags[FLAG_Z] = (w_res == '0);
        o_flags[FLAG_C] = w_c;
        o_flags[FLAG_V] = w_v;
    end

    assign o_result  = w_res;
    assign o_illegal = w_ill;

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle ops via alu_comb, plus an
// iterative shift-add multiplier that stalls in_ready for WIDTH cycles.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    seq_alu_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           r_state;
    logic [SH_W-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_illegal;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_alu_result;
    logic [3:0]       w_alu_flags;
    logic             w_alu_illegal;

    alu_comb #(
        .WIDTH  (WIDTH),
        .MUL_EN (MUL_EN)
    ) u_alu_comb (
        .i_cmd     (bus.exe_cmd),
        .i_a       (bus.val1),
        .i_b       (bus.val2),
        .i_c_in    (bus.c_in),
        .o_result  (w_alu_result),
        .o_flags   (w_alu_flags),
        .o_illegal (w_alu_illegal)
    );

    // A held result may be released and replaced in the same cycle.
    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready) && !flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mul   = MUL_EN && (bus.exe_cmd == CMD_MUL);
    assign w_last     = (r_cnt == SH_W'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= 4'b0000;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_cnt   <= '0;
                        end else begin
                            r_result    <= w_alu_result;
                            r_flags     <= w_alu_flags;
                            r_illegal   <= w_alu_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    // Fixed WIDTH iterations; the last one publishes its own partial sum.
                    if (w_last) begin
                        r_result    <= w_acc_next;
                        r_flags     <= nz_flags(w_acc_next[WIDTH-1], w_acc_next == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + SH_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Multiplier datapath; only meaningful while r_state is ST_MUL.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= bus.val1;
            r_mplier <= bus.val2;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: directed cases plus randomized ops against an arithmetic model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rnd_bp   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t        e;
        longint      ua, ub, sa, sbv, d, s, ci, maxs, mins;
        logic [63:0] p;
        logic signed [W-1:0] as;
        logic        c, v;
        logic [W-1:0] r;
        int          n;
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        maxs = 64'sd2147483647;
        mins = -maxs - 64'sd1;
        as   = $signed(a);
        n    = (b < 32'd32) ? int'(b) : 32;
        c    = 1'b0;
        v    = 1'b0;
        r    = '0;
        e.ill = 1'b0;
        case (cmd)
            CMD_ADD, CMD_ADC: begin
                ci = (cmd == CMD_ADC && cin) ? 64'sd1 : 64'sd0;
                d  = ua + ub + ci;
                r  = d[31:0];
                c  = d[32];
                s  = sa + sbv + ci;
                v  = (s > maxs) || (s < mins);
            end
            CMD_SUB, CMD_SBC: begin
                ci = (cmd == CMD_SBC && !cin) ? 64'sd1 : 64'sd0;
                d  = ua - ub - ci;
                r  = d[31:0];
                c  = (d >= 0);
                s  = sa - sbv - ci;
                v  = (s > maxs) || (s < mins);
            end
            CMD_AND: r = a & b;
            CMD_OR:  r = a | b;
            CMD_NOR: r = ~(a | b);
            CMD_XOR: r = a ^ b;
            CMD_SHL: if (n == 32) r = '0;
                     else begin r = a << n; c = (n == 0) ? 1'b0 : a[32-n]; end
            CMD_SRL: if (n == 32) r = '0;
                     else begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            CMD_SRA: if (n == 32) begin r = {W{a[31]}}; c = a[31]; end
                     else begin r = as >>> n; c = (n == 0) ? 1'b0 : a[n-1]; end
            CMD_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
            end
            default: e.ill = 1'b1;
        endcase
        e.res = r;
        e.flg = {r[31], (r == '0), c, v};
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a transfer happens on the next rising edge when both are high here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got result 0x%0h, want no output", bus.result);
            end else begin
                mon_e = sb.pop_front();
                check("sb_result",  64'(bus.result),  64'(mon_e.res));
                check("sb_flags",   64'(bus.flags),   64'(mon_e.flg));
                check("sb_illegal", 64'(bus.illegal), 64'(mon_e.ill));
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int waits);
        bus.exe_cmd  = cmd;
        bus.val1     = a;
        bus.val2     = b;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        waits        = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, want 1", waits);
        end else begin
            sb.push_back(model(cmd, a, b, cin));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int w, n, busy;
        logic [3:0]   cmd;
        logic [W-1:0] a, b;

        bus.in_valid  = 1'b0;
        bus.exe_cmd   = 4'h0;
        bus.val1      = '0;
        bus.val2      = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_flags",     64'(bus.flags),     64'd0);
        check("rst_illegal",   64'(bus.illegal),   64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1; bus.out_ready = 1'b1;

        send(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, w);
        @(negedge clk);
        check("add_valid",  64'(bus.out_valid), 64'd1);
        check("add_result", 64'(bus.result),    64'h8000_0000);
        check("add_flags",  64'(bus.flags),     64'b1001);
        @(posedge clk); #1;

        send(CMD_SUB, 32'd5, 32'd5, 1'b0, w);
        bus.exe_cmd = CMD_SBC; bus.val1 = 32'd5; bus.val2 = 32'd3; bus.c_in = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("sub_result",   64'(bus.result),   64'd0);
        check("sub_flags",    64'(bus.flags),    64'b0110);
        check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        sb.push_back(model(CMD_SBC, 32'd5, 32'd3, 1'b0));
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        check("sbc_result", 64'(bus.result),          64'd1);
        check("sbc_carry",  64'(bus.flags[FLAG_C]),   64'd1);
        @(posedge clk); #1;

        send(CMD_SRA, 32'h8000_0000, 32'h20, 1'b0, w);
        @(negedge clk);
        check("sra_result", 64'(bus.result),        64'hFFFF_FFFF);
        check("sra_carry",  64'(bus.flags[FLAG_C]), 64'd1);
        @(posedge clk); #1;

        send(CMD_SHL, 32'h8000_0001, 32'h1, 1'b0, w);
        @(negedge clk);
        check("shl_result", 64'(bus.result),        64'h2);
        check("shl_carry",  64'(bus.flags[FLAG_C]), 64'd1);
        @(posedge clk); #1;

        send(CMD_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0, w);
        n = 0; busy = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready) busy++;
            n++;
            @(negedge clk);
        end
        check("mul_latency",       64'(n),          64'(W));
        check("mul_ready_low",     64'(busy),       64'd0);
        check("mul_result",        64'(bus.result), 64'hFFFF_FFFF);
        check("mul_flags",         64'(bus.flags),  64'b1000);
        @(posedge clk); #1;

        bus.out_ready = 1'b0;
        send(CMD_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid",    64'(bus.out_valid), 64'd1);
            check("bp_result",   64'(bus.result),    64'h2345_6789);
            check("bp_in_ready", 64'(bus.in_ready),  64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(CMD_XOR, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0, w);
        check("bp_release_accept_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("bp_next_result", 64'(bus.result), 64'hFFFF_00FF);
        @(posedge clk); #1;

        send(4'hF, 32'h1, 32'h2, 1'b0, w);
        @(negedge clk);
        check("ill_result",  64'(bus.result),  64'd0);
        check("ill_flags",   64'(bus.flags),   64'b0100);
        check("ill_illegal", 64'(bus.illegal), 64'd1);
        @(posedge clk); #1;

        send(CMD_MUL, 32'd1234, 32'd5678, 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.exe_cmd = CMD_ADD; bus.val1 = 32'd7; bus.val2 = 32'd8; bus.in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("flush_no_result", 64'(n), 64'd0);
        @(posedge clk); #1;

        send(CMD_OR, 32'h5, 32'h3, 1'b0, w);
        @(negedge clk);
        check("or_result", 64'(bus.result), 64'h7);
        @(posedge clk); #1;
        send(CMD_MUL, 32'd3, 32'd5, 1'b0, w);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_result",    64'(bus.result),    64'd0);
        check("arst_flags",     64'(bus.flags),     64'd0);
        check("arst_in_ready",  64'(bus.in_ready),  64'd1);
        sb.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("arst_no_result", 64'(n), 64'd0);
        @(posedge clk); #1;

        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cmd = 4'($urandom_range(0, 15));
            a   = pick();
            if ((cmd == CMD_SHL || cmd == CMD_SRA || cmd == CMD_SRL) && $urandom_range(0, 3) != 0)
                b = 32'($urandom_range(0, 40));
            else
                b = pick();
            send(cmd, a, b, 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_bp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
